// File: rtl/rv_hazard_pkg.sv
// Shared definitions for the execute-stage hazard logic: forwarding select codes,
// the multi-cycle sequencer state type and the operand-forwarding select function.
package rv_hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  // The younger result (M) wins over W; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = FWD_MEM;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/mc_stall_sequencer.sv
// Holds a multi-cycle EX op in E: the op occupies EX for MC_LATENCY cycles,
// of which the first MC_LATENCY-1 assert McStall.
module mc_stall_sequencer
  import rv_hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic MultiCycleE,
  input  logic PCSrcE,
  output logic McStall
);

  localparam int CW = $clog2(MC_LATENCY + 1);
  // The IDLE cycle that accepts the op is the first stall; MC_BUSY supplies the rest.
  localparam logic [CW-1:0] CNT_START = CW'((MC_LATENCY > 2) ? (MC_LATENCY - 3) : 0);

  mc_state_t     state;
  logic [CW-1:0] cnt;
  logic          start;

  assign start   = (state == MC_IDLE) && MultiCycleE && !PCSrcE && (MC_LATENCY > 1);
  assign McStall = start || (state == MC_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (start && (MC_LATENCY > 2)) begin
            state <= MC_BUSY;
            cnt   <= CNT_START;
          end
        end
        MC_BUSY: begin
          if (cnt == '0)
            state <= MC_IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_hazard_controller.sv
// Execute-stage hazard control: operand forwarding selects, load-use and multi-cycle
// stalls, branch-redirect flushes, and stall/flush performance counters.
module ex_hazard_controller
  import rv_hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE,
  input  logic             MultiCycleE,
  input  logic             PCSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BubbleM,
  output logic             BusyE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic mc_stall;
  logic load_use;

  mc_stall_sequencer #(.MC_LATENCY(MC_LATENCY)) u_mc_seq (
    .clk        (clk),
    .rst        (rst),
    .MultiCycleE(MultiCycleE),
    .PCSrcE     (PCSrcE),
    .McStall    (mc_stall)
  );

  assign ForwardA_E = fwd_sel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
  assign ForwardB_E = fwd_sel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);

  assign load_use = ResultSrcE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // Redirect beats the multi-cycle hold, which beats load-use (E is not advancing).
  assign StallF  = !PCSrcE && (mc_stall || load_use);
  assign StallD  = StallF;
  assign StallE  = !PCSrcE && mc_stall;
  assign BubbleM = StallE;
  assign FlushD  = PCSrcE;
  assign FlushE  = PCSrcE || (!mc_stall && load_use);
  assign BusyE   = mc_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      StallCnt <= StallCnt + CNT_W'(StallF);
      FlushCnt <= FlushCnt + CNT_W'(PCSrcE);
    end
  end

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed and random checks of ex_hazard_controller (latency 4 and latency 1 instances)
// against a cycle-level reference model of the hazard rules.
module tb_ex_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       re, mce, pc, wm, ww;

  logic [1:0]  fa4, fb4, fa1, fb1;
  logic        sf4, sd4, se4, fd4, fe4, bm4, be4;
  logic        sf1, sd1, se1, fd1, fe1, bm1, be1;
  logic [31:0] sc4, fc4;
  logic [3:0]  sc1, fc1;

  int checks = 0;
  int errors = 0;

  // Reference model: stall cycles still owed by the op in E, and counter values.
  int          sl4, sl1;
  logic [31:0] ms4, mf4;
  logic [3:0]  ms1, mf1;

  ex_hazard_controller #(.MC_LATENCY(4), .CNT_W(32)) dut4 (
    .clk(clk), .rst(rst), .Rs1_D(rs1d), .Rs2_D(rs2d), .Rs1_E(rs1e), .Rs2_E(rs2e),
    .RD_E(rde), .ResultSrcE(re), .MultiCycleE(mce), .PCSrcE(pc),
    .RD_M(rdm), .RegWriteM(wm), .RD_W(rdw), .RegWriteW(ww),
    .ForwardA_E(fa4), .ForwardB_E(fb4), .StallF(sf4), .StallD(sd4), .StallE(se4),
    .FlushD(fd4), .FlushE(fe4), .BubbleM(bm4), .BusyE(be4),
    .StallCnt(sc4), .FlushCnt(fc4));

  ex_hazard_controller #(.MC_LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .Rs1_D(rs1d), .Rs2_D(rs2d), .Rs1_E(rs1e), .Rs2_E(rs2e),
    .RD_E(rde), .ResultSrcE(re), .MultiCycleE(mce), .PCSrcE(pc),
    .RD_M(rdm), .RegWriteM(wm), .RD_W(rdw), .RegWriteW(ww),
    .ForwardA_E(fa1), .ForwardB_E(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1), .BubbleM(bm1), .BusyE(be1),
    .StallCnt(sc1), .FlushCnt(fc1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (wm && rdm != 0 && rdm == rs) return 2'b10;
    if (ww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_mc(input int sl, input int lat);
    return (sl > 0) || (mce && !pc && lat > 1);
  endfunction

  function automatic logic model_lu();
    return re && rde != 0 && (rde == rs1d || rde == rs2d);
  endfunction

  function automatic int next_sl(input int sl, input int lat);
    int s;
    s = sl;
    if (rst) return 0;
    if (s == 0 && mce && !pc && lat > 1) s = lat - 1;
    if (s > 0) s--;
    return s;
  endfunction

  task automatic check_ctrl(input string n, input logic mc,
                            input logic sf, input logic sd, input logic se, input logic fd,
                            input logic fe, input logic bm, input logic be);
    logic lu;
    lu = model_lu();
    chk({n, ".StallF"},  sf, !pc && (mc || lu));
    chk({n, ".StallD"},  sd, !pc && (mc || lu));
    chk({n, ".StallE"},  se, !pc && mc);
    chk({n, ".FlushD"},  fd, pc);
    chk({n, ".FlushE"},  fe, pc || (!mc && lu));
    chk({n, ".BubbleM"}, bm, !pc && mc);
    chk({n, ".BusyE"},   be, mc);
  endtask

  // One clock: compare mid-cycle, take the edge, then advance the model.
  task automatic do_cycle();
    logic mc4, mc1;
    #2;
    mc4 = model_mc(sl4, 4);
    mc1 = model_mc(sl1, 1);
    chk("fwdA4", fa4, mfwd(rs1e));
    chk("fwdB4", fb4, mfwd(rs2e));
    chk("fwdA1", fa1, mfwd(rs1e));
    chk("fwdB1", fb1, mfwd(rs2e));
    chk("StallCnt4", sc4, ms4);
    chk("FlushCnt4", fc4, mf4);
    chk("StallCnt1", sc1, ms1);
    chk("FlushCnt1", fc1, mf1);
    if (!rst) begin
      check_ctrl("d4", mc4, sf4, sd4, se4, fd4, fe4, bm4, be4);
      check_ctrl("d1", mc1, sf1, sd1, se1, fd1, fe1, bm1, be1);
    end
    @(posedge clk);
    if (rst) begin
      ms4 = '0; mf4 = '0; ms1 = '0; mf1 = '0;
    end else begin
      ms4 = ms4 + 32'(!pc && (mc4 || model_lu()));
      ms1 = ms1 + 4'(!pc && (mc1 || model_lu()));
      mf4 = mf4 + 32'(pc);
      mf1 = mf1 + 4'(pc);
    end
    sl4 = next_sl(sl4, 4);
    sl1 = next_sl(sl1, 1);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    re = 0; mce = 0; pc = 0; wm = 0; ww = 0;
  endtask

  logic [31:0] base;

  initial begin
    sl4 = 0; sl1 = 0; ms4 = 0; mf4 = 0; ms1 = 0; mf1 = 0;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1; do_cycle();
    rst = 0;
    #1;
    chk("reset.StallCnt4", sc4, 32'd0);
    chk("reset.FlushCnt4", fc4, 32'd0);

    // Forwarding priority and x0
    wm = 1; rdm = 5; rs1e = 5; ww = 1; rdw = 5;
    #1; chk("fwd.M_priority", fa4, 2'b10);
    do_cycle();
    rdm = 0; rs2e = 0;
    #1; chk("fwd.W_when_M_x0", fa4, 2'b01);
    chk("fwd.x0_never", fb4, 2'b00);
    do_cycle();
    clear_inputs();

    // Load-use, then redirect overriding it
    re = 1; rde = 7; rs2d = 7;
    #1; chk("lu.StallF", sf4, 1'b1); chk("lu.FlushE", fe4, 1'b1);
    do_cycle();
    pc = 1;
    #1; chk("lu_pc.StallF", sf4, 1'b0); chk("lu_pc.FlushD", fd4, 1'b1);
    do_cycle();
    clear_inputs();

    // Multi-cycle op held in E for its stall cycles
    base = sc4;
    mce = 1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("mc.StallE", se4, 1'b1);
      do_cycle();
    end
    mce = 0;
    #1; chk("mc.after_StallE", se4, 1'b0);
    chk("mc.StallCnt_delta", sc4 - base, 32'd3);
    do_cycle();

    // Reset on the second MC_BUSY cycle aborts the op
    mce = 1;
    do_cycle();
    do_cycle();
    rst = 1;
    do_cycle();
    rst = 0; mce = 0;
    #1; chk("mcrst.StallE", se4, 1'b0);
    chk("mcrst.StallCnt", sc4, 32'd0);
    chk("mcrst.FlushCnt", fc4, 32'd0);
    do_cycle();

    // Latency 1: no stall; five flushes; counter wrap on 4-bit instance
    mce = 1;
    #1; chk("lat1.StallE", se1, 1'b0);
    do_cycle();
    clear_inputs();
    rst = 1; do_cycle(); rst = 0;
    pc = 1;
    for (int i = 0; i < 5; i++) do_cycle();
    pc = 0;
    #1; chk("lat1.FlushCnt5", fc1, 4'd5);
    re = 1; rde = 3; rs1d = 3;
    for (int i = 0; i < 16; i++) do_cycle();
    #1; chk("lat1.StallCnt_wrap", sc1, 4'd0);
    clear_inputs();
    do_cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rs1d = 5'($urandom_range(0, 7)); rs2d = 5'($urandom_range(0, 7));
      rs1e = 5'($urandom_range(0, 7)); rs2e = 5'($urandom_range(0, 7));
      rde  = 5'($urandom_range(0, 7)); rdm  = 5'($urandom_range(0, 7));
      rdw  = 5'($urandom_range(0, 7));
      re = ($urandom_range(0, 2) == 0);
      wm = $urandom_range(0, 1) != 0;
      ww = $urandom_range(0, 1) != 0;
      if (sl4 > 0) begin
        mce = 1; pc = 0;
      end else begin
        mce = ($urandom_range(0, 5) == 0);
        pc  = ($urandom_range(0, 7) == 0);
      end
      rst = ($urandom_range(0, 49) == 0);
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
